// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_ctrl_pkg: opcodes, sequencer states, instruction classes and the |
// | per-step strobe decode for the Mini SRC control unit.  Rev 1.0       |
// +----------------------------------------------------------------------+
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_MFHI = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    CL_ALU, CL_IMM, CL_NEGNOT, CL_MULDIV, CL_LD, CL_LDI, CL_ST, CL_BR,
    CL_JR, CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT
  } iclass_t;

  typedef struct packed {
    logic gra, grb, grc, rin, r_out, ba_out;
    logic pc_out, mdr_out, zhi_out, zlo_out, hi_out, lo_out, in_out, c_out;
    logic mar_in, mdr_in, pc_in, ir_in, y_in, z_in, hi_in, lo_in, con_in, out_rd;
    logic inc_pc, read, write;
    logic [4:0] op_sel;
    logic run;
  } ctl_t;

  function automatic state_t last_step(input logic [2:0] len);
    case (len)
      3'd1:    last_step = S_T3;
      3'd2:    last_step = S_T4;
      3'd3:    last_step = S_T5;
      3'd4:    last_step = S_T6;
      default: last_step = S_T7;
    endcase
  endfunction

  function automatic logic [4:0] imm_alu_op(input logic [4:0] op);
    case (op)
      OP_ANDI: imm_alu_op = OP_AND;
      OP_ORI:  imm_alu_op = OP_OR;
      default: imm_alu_op = OP_ADD;
    endcase
  endfunction

  // The conditional PC load in T6 of br is not produced here; it depends on live CON_FF.
  function automatic ctl_t ctl_decode(input state_t s, input iclass_t c, input logic [4:0] op);
    ctl_t k;
    k = '0;
    k.run = (s != S_RST) && (s != S_HALT);
    case (s)
      S_T0: begin k.pc_out = 1'b1; k.mar_in = 1'b1; k.inc_pc = 1'b1; k.z_in = 1'b1; end
      S_T1: begin k.zlo_out = 1'b1; k.pc_in = 1'b1; k.read = 1'b1; k.mdr_in = 1'b1; end
      S_T2: begin k.mdr_out = 1'b1; k.ir_in = 1'b1; end
      S_T3: case (c)
        CL_ALU, CL_IMM:      begin k.grb = 1'b1; k.r_out = 1'b1; k.y_in = 1'b1; end
        CL_NEGNOT:           begin k.grb = 1'b1; k.r_out = 1'b1; k.z_in = 1'b1; k.op_sel = op; end
        CL_MULDIV:           begin k.gra = 1'b1; k.r_out = 1'b1; k.y_in = 1'b1; end
        CL_LD, CL_LDI, CL_ST: begin k.grb = 1'b1; k.ba_out = 1'b1; k.y_in = 1'b1; end
        CL_BR:               begin k.gra = 1'b1; k.r_out = 1'b1; k.con_in = 1'b1; end
        CL_JR:               begin k.gra = 1'b1; k.r_out = 1'b1; k.pc_in = 1'b1; end
        CL_JAL:              begin k.pc_out = 1'b1; k.grb = 1'b1; k.rin = 1'b1; end
        CL_IN:               begin k.in_out = 1'b1; k.gra = 1'b1; k.rin = 1'b1; end
        CL_OUT:              begin k.gra = 1'b1; k.r_out = 1'b1; k.out_rd = 1'b1; end
        CL_MFHI:             begin k.hi_out = 1'b1; k.gra = 1'b1; k.rin = 1'b1; end
        CL_MFLO:             begin k.lo_out = 1'b1; k.gra = 1'b1; k.rin = 1'b1; end
        default: ;
      endcase
      S_T4: case (c)
        CL_ALU:              begin k.grc = 1'b1; k.r_out = 1'b1; k.z_in = 1'b1; k.op_sel = op; end
        CL_IMM:              begin k.c_out = 1'b1; k.z_in = 1'b1; k.op_sel = imm_alu_op(op); end
        CL_NEGNOT:           begin k.zlo_out = 1'b1; k.gra = 1'b1; k.rin = 1'b1; end
        // The ALU needs the opcode to tell mul from div.
        CL_MULDIV:           begin k.grb = 1'b1; k.r_out = 1'b1; k.z_in = 1'b1; k.op_sel = op; end
        CL_LD, CL_LDI, CL_ST: begin k.c_out = 1'b1; k.z_in = 1'b1; k.op_sel = OP_ADD; end
        CL_BR:               begin k.pc_out = 1'b1; k.y_in = 1'b1; end
        CL_JAL:              begin k.gra = 1'b1; k.r_out = 1'b1; k.pc_in = 1'b1; end
        default: ;
      endcase
      S_T5: case (c)
        CL_ALU, CL_IMM, CL_LDI: begin k.zlo_out = 1'b1; k.gra = 1'b1; k.rin = 1'b1; end
        CL_MULDIV:           begin k.zlo_out = 1'b1; k.lo_in = 1'b1; end
        CL_LD, CL_ST:        begin k.zlo_out = 1'b1; k.mar_in = 1'b1; end
        CL_BR:               begin k.c_out = 1'b1; k.z_in = 1'b1; k.op_sel = OP_ADD; end
        default: ;
      endcase
      S_T6: case (c)
        CL_MULDIV:           begin k.zhi_out = 1'b1; k.hi_in = 1'b1; end
        CL_LD:               begin k.read = 1'b1; k.mdr_in = 1'b1; end
        CL_ST:               begin k.gra = 1'b1; k.r_out = 1'b1; k.mdr_in = 1'b1; end
        default: ;
      endcase
      S_T7: case (c)
        CL_LD:               begin k.mdr_out = 1'b1; k.gra = 1'b1; k.rin = 1'b1; end
        CL_ST:               k.write = 1'b1;
        default: ;
      endcase
      default: ;
    endcase
    return k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_class_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_class_decode: opcode to instruction class and execute length.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module instr_class_decode
  import cpu_ctrl_pkg::*;
#(
  parameter bit LINK_RB = 1'b1
) (
  input  logic [4:0] opcode,
  output iclass_t    cls,
  output logic [2:0] exec_len
);

  always_comb begin
    cls = CL_NOP;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL: cls = CL_ALU;
      OP_ADDI, OP_ANDI, OP_ORI: cls = CL_IMM;
      OP_NEG, OP_NOT:           cls = CL_NEGNOT;
      OP_MUL, OP_DIV:           cls = CL_MULDIV;
      OP_LD:                    cls = CL_LD;
      OP_LDI:                   cls = CL_LDI;
      OP_ST:                    cls = CL_ST;
      OP_BR:                    cls = CL_BR;
      OP_JR:                    cls = CL_JR;
      OP_JAL:                   cls = LINK_RB ? CL_JAL : CL_NOP;
      OP_IN:                    cls = CL_IN;
      OP_OUT:                   cls = CL_OUT;
      OP_MFHI:                  cls = CL_MFHI;
      OP_MFLO:                  cls = CL_MFLO;
      OP_HALT:                  cls = CL_HALT;
      default:                  cls = CL_NOP;
    endcase

    case (cls)
      CL_ALU, CL_IMM, CL_LDI:          exec_len = 3'd3;
      CL_NEGNOT, CL_JAL:               exec_len = 3'd2;
      CL_MULDIV, CL_BR:                exec_len = 3'd4;
      CL_LD, CL_ST:                    exec_len = 3'd5;
      CL_JR, CL_IN, CL_OUT, CL_MFHI, CL_MFLO: exec_len = 3'd1;
      default:                         exec_len = 3'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | control_sequencer: hardwired fetch/execute control unit driving all  |
// | Mini SRC datapath strobes from registered state decode.  Rev 1.0     |
// +----------------------------------------------------------------------+
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter bit LINK_RB = 1'b1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        stop,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        R_out,
  output logic        BAout,
  output logic        PC_out,
  output logic        MDR_out,
  output logic        Zhi_out,
  output logic        Zlo_out,
  output logic        HI_out,
  output logic        LO_out,
  output logic        In_out,
  output logic        C_out,
  output logic        MARin,
  output logic        MDRin,
  output logic        PCin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        CONin,
  output logic        Out_rd,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  op_sel,
  output logic        run
);

  state_t     state, nxt_state;
  iclass_t    cls_q, nxt_cls, ir_cls;
  logic [4:0] op_q, nxt_op;
  logic [2:0] len_q, nxt_len, ir_len;
  ctl_t       ctl_q;
  logic       br_commit;

  // Register fields are consumed by the datapath's select-and-encode logic, not here.
  logic unused_ir;
  assign unused_ir = ^IR[26:0];

  instr_class_decode #(.LINK_RB(LINK_RB)) u_decode (
    .opcode   (IR[31:27]),
    .cls      (ir_cls),
    .exec_len (ir_len)
  );

  always_comb begin
    nxt_state = state;
    nxt_cls   = cls_q;
    nxt_op    = op_q;
    nxt_len   = len_q;
    case (state)
      S_RST:  nxt_state = S_T0;
      S_T0:   nxt_state = S_T1;
      S_T1:   nxt_state = S_T2;
      S_T2: begin
        nxt_cls = ir_cls;
        nxt_op  = IR[31:27];
        nxt_len = ir_len;
        if (ir_cls == CL_HALT)    nxt_state = S_HALT;
        else if (ir_len == 3'd0)  nxt_state = S_T0;
        else                      nxt_state = S_T3;
      end
      S_HALT: nxt_state = S_HALT;
      default: begin
        if (state == last_step(len_q)) begin
          nxt_state = stop ? S_HALT : S_T0;
        end else begin
          case (state)
            S_T3:    nxt_state = S_T4;
            S_T4:    nxt_state = S_T5;
            S_T5:    nxt_state = S_T6;
            S_T6:    nxt_state = S_T7;
            default: nxt_state = S_T0;
          endcase
        end
      end
    endcase
  end

  // Strobes are decoded from the next state so they are registered alongside it.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= S_RST;
      cls_q     <= CL_NOP;
      op_q      <= 5'd0;
      len_q     <= 3'd0;
      ctl_q     <= '0;
      br_commit <= 1'b0;
    end else begin
      state     <= nxt_state;
      cls_q     <= nxt_cls;
      op_q      <= nxt_op;
      len_q     <= nxt_len;
      ctl_q     <= ctl_decode(nxt_state, nxt_cls, nxt_op);
      br_commit <= (nxt_state == S_T6) && (nxt_cls == CL_BR);
    end
  end

  assign Gra     = ctl_q.gra;
  assign Grb     = ctl_q.grb;
  assign Grc     = ctl_q.grc;
  assign Rin     = ctl_q.rin;
  assign R_out   = ctl_q.r_out;
  assign BAout   = ctl_q.ba_out;
  assign PC_out  = ctl_q.pc_out;
  assign MDR_out = ctl_q.mdr_out;
  assign Zhi_out = ctl_q.zhi_out;
  assign Zlo_out = ctl_q.zlo_out | (br_commit & CON_FF);
  assign HI_out  = ctl_q.hi_out;
  assign LO_out  = ctl_q.lo_out;
  assign In_out  = ctl_q.in_out;
  assign C_out   = ctl_q.c_out;
  assign MARin   = ctl_q.mar_in;
  assign MDRin   = ctl_q.mdr_in;
  assign PCin    = ctl_q.pc_in | (br_commit & CON_FF);
  assign IRin    = ctl_q.ir_in;
  assign Yin     = ctl_q.y_in;
  assign Zin     = ctl_q.z_in;
  assign HIin    = ctl_q.hi_in;
  assign LOin    = ctl_q.lo_in;
  assign CONin   = ctl_q.con_in;
  assign Out_rd  = ctl_q.out_rd;
  assign IncPC   = ctl_q.inc_pc;
  assign Read    = ctl_q.read;
  assign Write   = ctl_q.write;
  assign op_sel  = ctl_q.op_sel;
  assign run     = ctl_q.run;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_control_sequencer: directed table plus random instruction stream  |
// | against a per-instruction step-list model.  Rev 1.0                  |
// +----------------------------------------------------------------------+
module tb_control_sequencer;

  localparam bit LINK_RB = 1'b1;

  typedef logic [26:0] strobe_t;
  localparam strobe_t M_GRA = 27'h0000001, M_GRB = 27'h0000002, M_GRC = 27'h0000004;
  localparam strobe_t M_RIN = 27'h0000008, M_ROUT = 27'h0000010, M_BAOUT = 27'h0000020;
  localparam strobe_t M_PCOUT = 27'h0000040, M_MDROUT = 27'h0000080, M_ZHIOUT = 27'h0000100;
  localparam strobe_t M_ZLOOUT = 27'h0000200, M_HIOUT = 27'h0000400, M_LOOUT = 27'h0000800;
  localparam strobe_t M_INOUT = 27'h0001000, M_COUT = 27'h0002000, M_MARIN = 27'h0004000;
  localparam strobe_t M_MDRIN = 27'h0008000, M_PCIN = 27'h0010000, M_IRIN = 27'h0020000;
  localparam strobe_t M_YIN = 27'h0040000, M_ZIN = 27'h0080000, M_HIIN = 27'h0100000;
  localparam strobe_t M_LOIN = 27'h0200000, M_CONIN = 27'h0400000, M_OUTRD = 27'h0800000;
  localparam strobe_t M_INCPC = 27'h1000000, M_READ = 27'h2000000, M_WRITE = 27'h4000000;

  logic clk = 1'b0;
  logic clr, CON_FF, stop;
  logic [31:0] IR;
  logic Gra, Grb, Grc, Rin, R_out, BAout, PC_out, MDR_out, Zhi_out, Zlo_out, HI_out, LO_out;
  logic In_out, C_out, MARin, MDRin, PCin, IRin, Yin, Zin, HIin, LOin, CONin, Out_rd;
  logic IncPC, Read, Write, run;
  logic [4:0] op_sel;

  always #5 clk = ~clk;

  control_sequencer #(.LINK_RB(LINK_RB)) dut (
    .clk(clk), .clr(clr), .IR(IR), .CON_FF(CON_FF), .stop(stop),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .R_out(R_out), .BAout(BAout),
    .PC_out(PC_out), .MDR_out(MDR_out), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out),
    .HI_out(HI_out), .LO_out(LO_out), .In_out(In_out), .C_out(C_out),
    .MARin(MARin), .MDRin(MDRin), .PCin(PCin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .HIin(HIin), .LOin(LOin), .CONin(CONin), .Out_rd(Out_rd),
    .IncPC(IncPC), .Read(Read), .Write(Write), .op_sel(op_sel), .run(run)
  );

  logic [32:0] dut_vec;
  assign dut_vec = {Write, Read, IncPC, Out_rd, CONin, LOin, HIin, Zin, Yin, IRin, PCin,
                    MDRin, MARin, C_out, In_out, LO_out, HI_out, Zlo_out, Zhi_out,
                    MDR_out, PC_out, BAout, R_out, Rin, Grc, Grb, Gra, op_sel, run};

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [32:0] exp);
    n_vec++;
    if (dut_vec !== exp) begin
      n_bad++;
      $display("FAIL %s: got strobes/op_sel/run=%h, expected %h", nm, dut_vec, exp);
    end
  endtask

  // Model: the full cycle-by-cycle strobe list of one instruction.
  strobe_t    m_s[8];
  logic [4:0] m_o[8];
  int         m_n;

  function automatic void push(input strobe_t s, input logic [4:0] o);
    if (m_n < 8) begin
      m_s[m_n] = s;
      m_o[m_n] = o;
      m_n++;
    end
  endfunction

  function automatic void model(input logic [4:0] op, input bit con);
    m_n = 0;
    push(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'd0);
    push(M_ZLOOUT | M_PCIN | M_READ | M_MDRIN, 5'd0);
    push(M_MDROUT | M_IRIN, 5'd0);
    if (op >= 5'd3 && op <= 5'd11) begin
      push(M_GRB | M_ROUT | M_YIN, 5'd0);
      push(M_GRC | M_ROUT | M_ZIN, op);
      push(M_ZLOOUT | M_GRA | M_RIN, 5'd0);
    end else if (op >= 5'd12 && op <= 5'd14) begin
      push(M_GRB | M_ROUT | M_YIN, 5'd0);
      push(M_COUT | M_ZIN, (op == 5'd12) ? 5'd3 : (op == 5'd13) ? 5'd5 : 5'd6);
      push(M_ZLOOUT | M_GRA | M_RIN, 5'd0);
    end else if (op == 5'd17 || op == 5'd18) begin
      push(M_GRB | M_ROUT | M_ZIN, op);
      push(M_ZLOOUT | M_GRA | M_RIN, 5'd0);
    end else if (op == 5'd15 || op == 5'd16) begin
      push(M_GRA | M_ROUT | M_YIN, 5'd0);
      push(M_GRB | M_ROUT | M_ZIN, op);
      push(M_ZLOOUT | M_LOIN, 5'd0);
      push(M_ZHIOUT | M_HIIN, 5'd0);
    end else if (op <= 5'd2) begin
      push(M_GRB | M_BAOUT | M_YIN, 5'd0);
      push(M_COUT | M_ZIN, 5'd3);
      if (op == 5'd1) begin
        push(M_ZLOOUT | M_GRA | M_RIN, 5'd0);
      end else begin
        push(M_ZLOOUT | M_MARIN, 5'd0);
        if (op == 5'd0) begin
          push(M_READ | M_MDRIN, 5'd0);
          push(M_MDROUT | M_GRA | M_RIN, 5'd0);
        end else begin
          push(M_GRA | M_ROUT | M_MDRIN, 5'd0);
          push(M_WRITE, 5'd0);
        end
      end
    end else if (op == 5'd19) begin
      push(M_GRA | M_ROUT | M_CONIN, 5'd0);
      push(M_PCOUT | M_YIN, 5'd0);
      push(M_COUT | M_ZIN, 5'd3);
      push(con ? (M_ZLOOUT | M_PCIN) : 27'd0, 5'd0);
    end else if (op == 5'd20) push(M_GRA | M_ROUT | M_PCIN, 5'd0);
    else if (op == 5'd21 && LINK_RB) begin
      push(M_PCOUT | M_GRB | M_RIN, 5'd0);
      push(M_GRA | M_ROUT | M_PCIN, 5'd0);
    end
    else if (op == 5'd22) push(M_INOUT | M_GRA | M_RIN, 5'd0);
    else if (op == 5'd23) push(M_GRA | M_ROUT | M_OUTRD, 5'd0);
    else if (op == 5'd24) push(M_LOOUT | M_GRA | M_RIN, 5'd0);
    else if (op == 5'd25) push(M_HIOUT | M_GRA | M_RIN, 5'd0);
  endfunction

  // Entered and left at a falling edge with the DUT in T0.
  task automatic do_reset(input string nm);
    clr = 1'b1;
    #1 check({nm, "_clr_assert"}, 33'd0);
    @(negedge clk);
    clr = 1'b0;
    #1 check({nm, "_rst_state"}, 33'd0);
    @(negedge clk);
  endtask

  task automatic exec_instr(input logic [31:0] ir, input bit con, input bit stp,
                            input bit exp_halt, input int hold, input int abort_at,
                            input string nm);
    model(ir[31:27], con);
    IR = ir;
    CON_FF = con;
    for (int k = 0; k < m_n; k++) begin
      if (k >= 3) IR = $urandom;
      stop = (k == m_n - 1) ? stp : 1'($urandom_range(0, 1));
      #1 check($sformatf("%s_step%0d", nm, k), {m_s[k], m_o[k], 1'b1});
      if (k == abort_at) begin
        stop = 1'b0;
        do_reset({nm, "_abort"});
        return;
      end
      @(posedge clk);
      @(negedge clk);
    end
    stop = 1'b0;
    if (exp_halt) begin
      for (int h = 0; h < hold; h++) begin
        #1 check($sformatf("%s_halt%0d", nm, h), 33'd0);
        @(negedge clk);
      end
      do_reset({nm, "_exit"});
    end
  endtask

  typedef struct {
    logic [31:0] ir;
    bit          con;
    bit          stp;
    bit          halts;
    int          hold;
    int          abort_at;
    string       nm;
  } vec_t;

  vec_t tbl[24];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] rop;
    bit         rcon, rstp, rhalt;
    int         rab;

    tbl[0]  = '{32'h1A920000, 1'b0, 1'b0, 1'b0, 0, -1, "add"};
    tbl[1]  = '{32'h1A920000, 1'b0, 1'b0, 1'b0, 0,  4, "add_reset_t4"};
    tbl[2]  = '{32'h00800054, 1'b0, 1'b0, 1'b0, 0, -1, "ld"};
    tbl[3]  = '{32'h99000005, 1'b0, 1'b0, 1'b0, 0, -1, "br_con0"};
    tbl[4]  = '{32'h99000005, 1'b1, 1'b0, 1'b0, 0, -1, "br_con1"};
    tbl[5]  = '{32'hD0000000, 1'b0, 1'b0, 1'b0, 0, -1, "nop"};
    tbl[6]  = '{32'hD0000000, 1'b0, 1'b1, 1'b0, 0, -1, "nop_stop_ignored"};
    tbl[7]  = '{32'h81100000, 1'b0, 1'b0, 1'b0, 0, -1, "mul"};
    tbl[8]  = '{32'h79100000, 1'b0, 1'b0, 1'b0, 0, -1, "div"};
    tbl[9]  = '{32'h10800054, 1'b0, 1'b0, 1'b0, 0, -1, "st"};
    tbl[10] = '{32'h08800054, 1'b0, 1'b0, 1'b0, 0, -1, "ldi"};
    tbl[11] = '{32'h60880007, 1'b0, 1'b0, 1'b0, 0, -1, "addi"};
    tbl[12] = '{32'h68880007, 1'b0, 1'b0, 1'b0, 0, -1, "andi"};
    tbl[13] = '{32'h70880007, 1'b0, 1'b0, 1'b0, 0, -1, "ori"};
    tbl[14] = '{32'h88900000, 1'b0, 1'b0, 1'b0, 0, -1, "neg"};
    tbl[15] = '{32'h90900000, 1'b0, 1'b0, 1'b0, 0, -1, "not"};
    tbl[16] = '{32'hA0800000, 1'b0, 1'b0, 1'b0, 0, -1, "jr"};
    tbl[17] = '{32'hA8880000, 1'b0, 1'b0, 1'b0, 0, -1, "jal"};
    tbl[18] = '{32'hB0800000, 1'b0, 1'b0, 1'b0, 0, -1, "in"};
    tbl[19] = '{32'hB8800000, 1'b0, 1'b0, 1'b0, 0, -1, "out"};
    tbl[20] = '{32'hC0800000, 1'b0, 1'b0, 1'b0, 0, -1, "mflo"};
    tbl[21] = '{32'hF8000000, 1'b0, 1'b0, 1'b0, 0, -1, "undefined"};
    tbl[22] = '{32'h1A920000, 1'b0, 1'b1, 1'b1, 3, -1, "add_stop"};
    tbl[23] = '{32'hD8000000, 1'b0, 1'b0, 1'b1, 10, -1, "halt"};

    clr = 1'b1;
    IR = 32'd0;
    CON_FF = 1'b0;
    stop = 1'b0;
    repeat (2) @(negedge clk);
    #1 check("reset_held", 33'd0);
    clr = 1'b0;
    #1 check("reset_release_rst", 33'd0);
    @(negedge clk);

    for (int i = 0; i < 24; i++)
      exec_instr(tbl[i].ir, tbl[i].con, tbl[i].stp, tbl[i].halts, tbl[i].hold,
                 tbl[i].abort_at, tbl[i].nm);

    for (int i = 0; i < 250; i++) begin
      rop  = 5'($urandom_range(0, 31));
      rcon = 1'($urandom_range(0, 1));
      rstp = ($urandom_range(0, 7) == 0);
      model(rop, rcon);
      rhalt = (rop == 5'd27) || (rstp && m_n > 3);
      rab = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, m_n - 1)) : -1;
      exec_instr({rop, 27'($urandom)}, rcon, rstp, rhalt, 2, rab,
                 $sformatf("rand%0d_op%0d", i, rop));
    end

    #1 check("final_t0", {M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'd0, 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
